// File: rtl/aes_mixcol_engine.sv
// Handshaked AES (Inv)MixColumns engine: LANES output bytes per 4-cycle
// multiply-accumulate pass over a buffered 128-bit state, one block in flight.
module aes_mixcol_engine #(
  parameter int unsigned LANES  = 1,
  parameter bit          INV_EN = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         inverse,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
);

  localparam int unsigned GROUPS = (LANES == 0) ? 1 : 16 / LANES;
  localparam int unsigned GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_lanes_check
      $error("aes_mixcol_engine: LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_out_valid;
  logic [7:0]        r_in_buf [16];
  logic [7:0]        r_result [16];
  logic [7:0]        r_acc    [LANES];
  logic              r_inv;
  logic [GW-1:0]     r_g;
  logic [1:0]        r_t;
  logic              w_accept;
  logic              w_last_term;
  logic              w_last_grp;
  logic [LANES*8-1:0] w_terms;
  logic [LANES*4-1:0] w_js;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  assign w_last_term = (r_t == 2'd3);
  assign w_last_grp  = (r_g == GW'(GROUPS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_out_valid <= (w_next == S_DONE);
    end
  end

  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    busy     = 1'b0;
    w_accept = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last_term && w_last_grp) w_next = S_DONE;
      end
      S_DONE: begin
        busy = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign out_valid = r_out_valid;

  // Coefficients depend only on t: the row rotation is folded into the
  // operand index (r+t)%4, so every row uses the unrotated base sequence.
  generate
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [3:0] w_j;
      logic [3:0] w_idx;
      logic [7:0] w_a;
      logic [7:0] w_x2;
      logic [7:0] w_x4;
      logic [7:0] w_x8;
      logic [7:0] w_term;

      assign w_j   = 4'(32'(r_g) * LANES + 32'(l));
      assign w_idx = {w_j[3:2], 2'(w_j[1:0] + r_t)};
      assign w_a   = r_in_buf[w_idx];
      assign w_x2  = xtime(w_a);
      assign w_x4  = xtime(w_x2);
      assign w_x8  = xtime(w_x4);

      always_comb begin
        w_term = w_a;
        if (INV_EN && r_inv) begin
          unique case (r_t)
            2'd0:    w_term = w_x8 ^ w_x4 ^ w_x2;
            2'd1:    w_term = w_x8 ^ w_x2 ^ w_a;
            2'd2:    w_term = w_x8 ^ w_x4 ^ w_a;
            default: w_term = w_x8 ^ w_a;
          endcase
        end else begin
          unique case (r_t)
            2'd0:    w_term = w_x2;
            2'd1:    w_term = w_x2 ^ w_a;
            default: w_term = w_a;
          endcase
        end
      end

      assign w_terms[8*l +: 8] = w_term;
      assign w_js[4*l +: 4]    = w_j;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 16; i++) begin
        r_in_buf[i] <= '0;
        r_result[i] <= '0;
      end
      for (int unsigned l = 0; l < LANES; l++) r_acc[l] <= '0;
      r_inv <= 1'b0;
      r_g   <= '0;
      r_t   <= '0;
    end else if (w_accept) begin
      for (int unsigned i = 0; i < 16; i++) r_in_buf[i] <= state_in[8*i +: 8];
      for (int unsigned l = 0; l < LANES; l++) r_acc[l] <= '0;
      r_inv <= inverse & INV_EN;
      r_g   <= '0;
      r_t   <= '0;
    end else if (r_state == S_RUN) begin
      r_t <= r_t + 2'd1;
      for (int unsigned l = 0; l < LANES; l++) begin
        if (w_last_term) begin
          r_result[w_js[4*l +: 4]] <= r_acc[l] ^ w_terms[8*l +: 8];
          r_acc[l]                 <= '0;
        end else begin
          r_acc[l] <= r_acc[l] ^ w_terms[8*l +: 8];
        end
      end
      if (w_last_term && !w_last_grp) r_g <= r_g + GW'(1);
    end
  end

  generate
    for (genvar i = 0; i < 16; i++) begin : g_out
      assign state_out[8*i +: 8] = r_result[i];
    end
  endgenerate

endmodule

// File: tb/tb_aes_mixcol_engine.sv
// Bench for aes_mixcol_engine: six instances (LANES 1..16 with inverse support,
// plus a forward-only LANES=4 build) checked against a GF(2^8) matrix model.
module tb_aes_mixcol_engine;

  localparam int NI = 6;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid_a  [NI];
  logic         in_ready_a  [NI];
  logic         inverse_a   [NI];
  logic [127:0] state_in_a  [NI];
  logic         out_valid_a [NI];
  logic         out_ready_a [NI];
  logic [127:0] state_out_a [NI];
  logic         busy_a      [NI];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  generate
    for (genvar k = 0; k < NI; k++) begin : g_dut
      aes_mixcol_engine #(
        .LANES  ((k == 5) ? 4 : (1 << k)),
        .INV_EN (k != 5)
      ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid_a[k]),
        .in_ready  (in_ready_a[k]),
        .inverse   (inverse_a[k]),
        .state_in  (state_in_a[k]),
        .out_valid (out_valid_a[k]),
        .out_ready (out_ready_a[k]),
        .state_out (state_out_a[k]),
        .busy      (busy_a[k])
      );
    end
  endgenerate

  function automatic int lanes_of(input int k);
    return (k == 5) ? 4 : (1 << k);
  endfunction

  function automatic logic [127:0] bswap(input logic [127:0] v);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = v[8*(15-i) +: 8];
    return o;
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  // out[4c+r] = sum_i M[r][i] * a[4c+i], M row r = base rotated right by r
  function automatic logic [127:0] mixcol_ref(input logic [127:0] s, input logic inv);
    logic [7:0]   base [4];
    logic [127:0] o;
    logic [7:0]   acc;
    if (inv) base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     base = '{8'h02, 8'h03, 8'h01, 8'h01};
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = '0;
        for (int i = 0; i < 4; i++)
          acc = acc ^ gmul(base[(i - r + 4) % 4], s[8*(4*c+i) +: 8]);
        o[8*(4*c+r) +: 8] = acc;
      end
    return o;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_block(input int k, input logic [127:0] din, input logic inv,
                           output logic [127:0] res, output int lat);
    @(negedge clk);
    in_valid_a[k]  = 1'b1;
    state_in_a[k]  = din;
    inverse_a[k]   = inv;
    out_ready_a[k] = 1'b0;
    chk("in_ready_before_accept", 128'(in_ready_a[k]), 128'd1);
    @(posedge clk);
    #1;
    in_valid_a[k] = 1'b0;
    chk("in_ready_in_run", 128'(in_ready_a[k]), 128'd0);
    chk("busy_in_run", 128'(busy_a[k]), 128'd1);
    lat = 0;
    while (!out_valid_a[k] && lat < 300) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = state_out_a[k];
    @(negedge clk);
    out_ready_a[k] = 1'b1;
    @(posedge clk);
    #1;
    out_ready_a[k] = 1'b0;
    chk("out_valid_after_retire", 128'(out_valid_a[k]), 128'd0);
    chk("in_ready_after_retire", 128'(in_ready_a[k]), 128'd1);
  endtask

  typedef struct {
    logic [127:0] din;
    logic         inv;
    logic [127:0] dexp;
  } vec_t;

  vec_t         vt [4];
  logic [127:0] res;
  logic [127:0] held;
  logic [127:0] din;
  logic         inv;
  int           lat;
  int           k;
  int           acc_cyc [$];

  initial begin
    for (int i = 0; i < NI; i++) begin
      in_valid_a[i]  = 1'b0;
      inverse_a[i]   = 1'b0;
      state_in_a[i]  = '0;
      out_ready_a[i] = 1'b0;
    end

    vt[0] = '{bswap(128'hdb135345_00000000_00000000_00000000), 1'b0,
              bswap(128'h8e4da1bc_00000000_00000000_00000000)};
    vt[1] = '{bswap(128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5), 1'b0,
              bswap(128'h046681e5_e0cb199a_48f8d37a_2806264c)};
    vt[2] = '{bswap(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6), 1'b1,
              bswap(128'hdb135345_f20a225c_01010101_c6c6c6c6)};
    vt[3] = '{bswap(128'h01010101_01010101_01010101_01010101), 1'b0,
              bswap(128'h01010101_01010101_01010101_01010101)};

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("reset_in_ready", 128'(in_ready_a[i]), 128'd1);
      chk("reset_out_valid", 128'(out_valid_a[i]), 128'd0);
      chk("reset_busy", 128'(busy_a[i]), 128'd0);
      chk("reset_state_out", state_out_a[i], 128'd0);
    end

    // Known vectors on every build; the forward-only build ignores inverse.
    for (int v = 0; v < 4; v++)
      for (int i = 0; i < NI; i++) begin
        run_block(i, vt[v].din, vt[v].inv, res, lat);
        if (i == 5) chk("vec_fwd_only", res, mixcol_ref(vt[v].din, 1'b0));
        else        chk("vec_result", res, vt[v].dexp);
        chk("vec_latency", 128'(lat), 128'(64 / lanes_of(i)));
      end

    for (int n = 0; n < 24; n++) begin
      k   = $urandom_range(0, NI - 1);
      din = {$urandom, $urandom, $urandom, $urandom};
      inv = 1'($urandom_range(0, 1));
      run_block(k, din, inv, res, lat);
      chk("rand_result", res, mixcol_ref(din, inv && (k != 5)));
      chk("rand_latency", 128'(lat), 128'(64 / lanes_of(k)));
    end

    // Backpressure on LANES=4: result held, in_valid ignored in DONE.
    k = 2;
    din = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    in_valid_a[k] = 1'b1; state_in_a[k] = din; inverse_a[k] = 1'b0; out_ready_a[k] = 1'b0;
    @(posedge clk); #1;
    in_valid_a[k] = 1'b0;
    lat = 0;
    while (!out_valid_a[k] && lat < 300) begin
      @(posedge clk); #1; lat++;
    end
    chk("bp_latency", 128'(lat), 128'd16);
    chk("bp_result", state_out_a[k], mixcol_ref(din, 1'b0));
    held = state_out_a[k];
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      in_valid_a[k] = (c == 5);
      state_in_a[k] = ~din;
      @(posedge clk); #1;
      chk("bp_hold_state", state_out_a[k], held);
      chk("bp_hold_in_ready", 128'(in_ready_a[k]), 128'd0);
      chk("bp_hold_out_valid", 128'(out_valid_a[k]), 128'd1);
    end
    @(negedge clk);
    out_ready_a[k] = 1'b1; in_valid_a[k] = 1'b1; state_in_a[k] = ~din;
    @(posedge clk); #1;
    chk("bp_retire_out_valid", 128'(out_valid_a[k]), 128'd0);
    chk("bp_retire_in_ready", 128'(in_ready_a[k]), 128'd1);
    chk("bp_retire_busy", 128'(busy_a[k]), 128'd0);
    @(negedge clk);
    out_ready_a[k] = 1'b0;
    @(posedge clk); #1;
    in_valid_a[k] = 1'b0;
    chk("bp_next_accepted", 128'(in_ready_a[k]), 128'd0);
    lat = 0;
    while (!out_valid_a[k] && lat < 300) begin
      @(posedge clk); #1; lat++;
    end
    chk("bp_next_latency", 128'(lat), 128'd16);
    chk("bp_next_result", state_out_a[k], mixcol_ref(~din, 1'b0));
    @(negedge clk); out_ready_a[k] = 1'b1;
    @(posedge clk); #1; out_ready_a[k] = 1'b0;

    // Back-to-back on LANES=8 (N=8): accepts N+2 cycles apart.
    k = 3;
    din = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    in_valid_a[k] = 1'b1; state_in_a[k] = din; inverse_a[k] = 1'b1; out_ready_a[k] = 1'b1;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      if (in_ready_a[k]) acc_cyc.push_back(cyc);
      if (out_valid_a[k]) chk("b2b_result", state_out_a[k], mixcol_ref(din, 1'b1));
    end
    in_valid_a[k] = 1'b0;
    chk("b2b_accept_count", 128'(acc_cyc.size() >= 3), 128'd1);
    for (int i = 1; i < acc_cyc.size(); i++)
      chk("b2b_ii", 128'(acc_cyc[i] - acc_cyc[i-1]), 128'd10);
    lat = 0;
    while (!in_ready_a[k] && lat < 100) begin
      @(negedge clk); lat++;
    end
    out_ready_a[k] = 1'b0;

    // Reset mid-RUN on LANES=2.
    k = 1;
    din = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    in_valid_a[k] = 1'b1; state_in_a[k] = din; inverse_a[k] = 1'b0;
    @(posedge clk); #1;
    in_valid_a[k] = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_out_valid", 128'(out_valid_a[k]), 128'd0);
    chk("rst_state_out", state_out_a[k], 128'd0);
    chk("rst_in_ready", 128'(in_ready_a[k]), 128'd1);
    chk("rst_busy", 128'(busy_a[k]), 128'd0);
    @(negedge clk);
    reset = 1'b0;
    din = {$urandom, $urandom, $urandom, $urandom};
    run_block(k, din, 1'b1, res, lat);
    chk("rst_next_result", res, mixcol_ref(din, 1'b1));
    chk("rst_next_latency", 128'(lat), 128'd32);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_mixcol_engine.md
# aes_mixcol_engine

Parametrised, handshaked AES MixColumns engine that computes forward or inverse MixColumns on a full 128-bit state. Each lane computes one output byte per 4-cycle multiply-accumulate pass, so LANES trades area against latency. It sits between ShiftRows and AddRoundKey in the round datapath and is also used unmodified in the decryption path via the `inverse` input.

## Interface
- LANES, 1: output bytes computed in parallel. Legal values are 1, 2, 4, 8, 16; any other value must fail elaboration.
- INV_EN, 1: 1 builds the inverse-coefficient datapath. With 0 the `inverse` input is ignored and the block is forward-only.

- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high. One clock; reset is synchronous and active-high.
- in_valid  in  1  state_in/inverse are valid.
- in_ready  out  1  engine accepts a block; high only in IDLE.
- inverse  in  1  0 = MixColumns, 1 = InvMixColumns. Sampled on the accept cycle.
- state_in  in  128  byte k = state_in[8k+7:8k]; column c = bytes 4c..4c+3; row r = byte 4c+r.
- out_valid  out  1  state_out holds a completed result.
- out_ready  in  1  consumer accepts the result.
- state_out  out  128  result, same byte ordering as state_in.
- busy  out  1  high in RUN or DONE.

## Operation
- Arithmetic is GF(2^8) mod 0x11b.
  - xtime(a) = (a<<1)[7:0] ^ (a[7] ? 0x1b : 0).
  - Forward coefficients per row r: (2,3,1,1) rotated right by r.
  - Inverse coefficients: (0e,0b,0d,09) rotated right by r.
  - Multiplication by 9/b/d/e is built from xtime chains (x2, x4, x8) XORed together. All values are 8-bit; no carries escape.
- Output byte j (c=j/4, r=j%4) = XOR over t=0..3 of coef(r,t)·a[4c+((r+t)%4)]. Example: forward row 0 = 2·a0 ^ 3·a1 ^ a2 ^ a3.
- Internal registers:
  - in_buf (128 bits), inv_q, group counter g (0..16/LANES-1), term counter t (0..3).
  - LANES 8-bit accumulators and the 128-bit result register driving state_out.
- FSM states:
  - IDLE: in_ready=1. On in_valid: latch state_in→in_buf, inverse&INV_EN→inv_q; clear g, t, accumulators; go to RUN.
  - RUN: each cycle, lane l (byte j=g·LANES+l) does acc_l ^= coef(r,t)·a[...], and t increments.
    - At t=3, the final XOR is written directly into result byte j, accumulators clear, t wraps to 0 and g increments.
    - At t=3 with g=last, go to DONE.
  - DONE: out_valid=1, state_out stable. On out_ready go to IDLE. in_valid is ignored.
- The block is not pipelined: one block in flight.
- Result bytes not yet rewritten keep their previous-block value during RUN. Consumers may only sample on out_valid.
- Reset in any state: next cycle the FSM is in IDLE, all counters, accumulators, in_buf and state_out are 0, and out_valid=0. An in-flight block is discarded, not completed.

## Timing
- Reset values: in_ready=1 (IDLE, after reset released), out_valid=0, busy=0, state_out=0.
- N = 64/LANES RUN cycles.
- If accept happens at edge E, out_valid is high from edge E+1+N−1 = E+N. Latency is therefore N cycles: 64 at LANES=1, 4 at LANES=16.
- in_ready drops the cycle after accept and returns the cycle after the out_valid&out_ready edge.
- Minimum initiation interval: N+2 cycles with out_ready tied high.
- out_valid, once high, stays high with state_out constant until out_ready is sampled high; there is no timeout.
- in_ready and busy are combinational decodes of the state register. out_valid is registered (it equals state==DONE).
- A simultaneous in_valid and out_ready in DONE retires the result only. The new block is accepted no earlier than the next IDLE cycle.

## Test plan
- Forward column vector, LANES=1: column0 = db 13 53 45, others 0 → state_out column0 = 8e 4d a1 bc, others 0. out_valid exactly 64 cycles after accept.
- FIPS-197 round-1 state d4 bf 5d 30 | e0 b4 52 ae | b8 41 11 f1 | 1e 27 98 e5 → 04 66 81 e5 | e0 cb 19 9a | 48 f8 d3 7a | 28 06 26 4c. Run for every legal LANES; latency must be 64/LANES.
- Inverse: feed 8e 4d a1 bc | 9f dc 58 9d | 01 01 01 01 | c6 c6 c6 c6 with inverse=1 → db 13 53 45 | f2 0a 22 5c | 01 01 01 01 | c6 c6 c6 c6. With INV_EN=0 and the same stimulus, the output is the forward result.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid → state_out constant, in_ready=0, and an in_valid pulse is ignored. Raise out_ready → IDLE next cycle, then accept the next block. Back-to-back blocks with out_ready=1 → II = N+2.
- Reset mid-RUN (LANES=2, cycle 10 of 32) → next cycle: out_valid=0, state_out=0, in_ready=1. The next accepted block produces the correct result.
- Illegal LANES=3 → elaboration error.
